// File: rtl/score_arbiter.sv
// Round-robin arbiter that turns request edges from three requesters into
// fixed-amount increments offered to a counter, with a post-handshake holdoff.
module score_arbiter #(
    parameter int unsigned HOLDOFF = 4,
    parameter int unsigned AMT0    = 1,
    parameter int unsigned AMT1    = 2,
    parameter int unsigned AMT2    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       inc_ready,
    output logic       inc_valid,
    output logic [3:0] inc_amount,
    output logic [1:0] grant_id,
    output logic [2:0] pending,
    output logic       dropped,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    localparam logic [3:0] AMT0_W    = 4'(AMT0);
    localparam logic [3:0] AMT1_W    = 4'(AMT1);
    localparam logic [3:0] AMT2_W    = 4'(AMT2);
    // Last count value spent in HOLD; unused when HOLDOFF is zero.
    localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF - 1);

    state_t     state_q, state_d;
    logic [2:0] pending_q, pending_d;
    logic [2:0] req_prev_q, req_prev_d;
    logic       dropped_q, dropped_d;
    logic [1:0] last_grant_q, last_grant_d;
    logic [1:0] grant_q, grant_d;
    logic [3:0] amount_q, amount_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;

    logic [2:0] req_event;
    logic [2:0] clr;
    logic [1:0] sel;

    function automatic logic [3:0] amount_of(input logic [1:0] id);
        case (id)
            2'd0:    amount_of = AMT0_W;
            2'd1:    amount_of = AMT1_W;
            default: amount_of = AMT2_W;
        endcase
    endfunction

    assign req_event = req & ~req_prev_q;

    // Round-robin pick: first pending index above last_grant, wrapping mod 3.
    always_comb begin
        sel = 2'd0;
        case (last_grant_q)
            2'd0: begin
                if (pending_q[1])      sel = 2'd1;
                else if (pending_q[2]) sel = 2'd2;
                else                   sel = 2'd0;
            end
            2'd1: begin
                if (pending_q[2])      sel = 2'd2;
                else if (pending_q[0]) sel = 2'd0;
                else                   sel = 2'd1;
            end
            default: begin
                if (pending_q[0])      sel = 2'd0;
                else if (pending_q[1]) sel = 2'd1;
                else                   sel = 2'd2;
            end
        endcase
    end

    // Next-state, grant loading, holdoff counting and pending/dropped bookkeeping.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        amount_d     = amount_q;
        hold_cnt_d   = hold_cnt_q;
        req_prev_d   = req;
        clr          = 3'b000;

        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    state_d      = S_ISSUE;
                    clr[sel]     = 1'b1;
                    last_grant_d = sel;
                    grant_d      = sel;
                    amount_d     = amount_of(sel);
                end
            end
            S_ISSUE: begin
                if (inc_ready) begin
                    hold_cnt_d = 4'd0;
                    state_d    = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_IDLE;
                    hold_cnt_d = 4'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An event on a bit being granted this edge re-arms it without a drop.
        pending_d = (pending_q & ~clr) | req_event;
        dropped_d = dropped_q | (|(req_event & pending_q & ~clr));
    end

    // State register; req_prev keeps tracking req through reset.
    always_ff @(posedge clk) begin
        req_prev_q <= req_prev_d;
        if (rst) begin
            state_q      <= S_IDLE;
            pending_q    <= 3'b000;
            dropped_q    <= 1'b0;
            last_grant_q <= 2'd2;
            grant_q      <= 2'd0;
            amount_q     <= 4'd0;
            hold_cnt_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            dropped_q    <= dropped_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            amount_q     <= amount_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign inc_valid  = (state_q == S_ISSUE);
    assign inc_amount = inc_valid ? amount_q : 4'd0;
    assign grant_id   = inc_valid ? grant_q : 2'd0;
    assign pending    = pending_q;
    assign dropped    = dropped_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_score_arbiter.sv
// Bench for score_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all compared each cycle against a behavioural model.
module tb_score_arbiter;

    localparam int HOLDOFF = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       inc_ready;
    logic       inc_valid;
    logic [3:0] inc_amount;
    logic [1:0] grant_id;
    logic [2:0] pending;
    logic       dropped;
    logic       busy;

    int checks = 0;
    int errors = 0;

    score_arbiter #(.HOLDOFF(HOLDOFF), .AMT0(1), .AMT1(2), .AMT2(3)) dut (
        .clk(clk), .rst(rst), .req(req), .inc_ready(inc_ready),
        .inc_valid(inc_valid), .inc_amount(inc_amount), .grant_id(grant_id),
        .pending(pending), .dropped(dropped), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 = waiting, 1 = offering, 2 = holding off.
    int       m_phase = 0;
    bit [2:0] m_pend = 0;
    bit [2:0] m_prev = 0;
    bit       m_drop = 0;
    int       m_last = 2;
    int       m_id = 0;
    int       m_left = 0;
    int       amt_tab[3] = '{1, 2, 3};

    task automatic model_step(input bit r, input bit [2:0] q, input bit rd);
        bit [2:0] ev;
        bit [2:0] taken;
        if (r) begin
            m_phase = 0; m_pend = 0; m_drop = 0; m_last = 2; m_id = 0; m_left = 0;
            m_prev  = q;
            return;
        end
        ev     = q & ~m_prev;
        m_prev = q;
        taken  = 0;
        if (m_phase == 0) begin
            if (m_pend != 0) begin
                for (int k = 1; k <= 3; k++) begin
                    if (m_pend[(m_last + k) % 3]) begin
                        m_id = (m_last + k) % 3;
                        break;
                    end
                end
                taken[m_id] = 1'b1;
                m_last  = m_id;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (rd) begin
                m_left  = HOLDOFF;
                m_phase = (HOLDOFF == 0) ? 0 : 2;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_phase = 0;
        end
        for (int i = 0; i < 3; i++) begin
            if (ev[i] && m_pend[i] && !taken[i]) m_drop = 1'b1;
        end
        m_pend = (m_pend & ~taken) | ev;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        bit v;
        v = (m_phase == 1);
        chk("model.inc_valid", inc_valid, v);
        chk("model.inc_amount", inc_amount, v ? amt_tab[m_id] : 0);
        chk("model.grant_id", grant_id, v ? m_id : 0);
        chk("model.pending", pending, m_pend);
        chk("model.dropped", dropped, m_drop);
        chk("model.busy", busy, m_phase != 0);
    endtask

    // One clock: drive inputs, advance model, sample DUT on the falling edge.
    task automatic tick(input bit r, input bit [2:0] q, input bit rd);
        rst = r; req = q; inc_ready = rd;
        model_step(r, q, rd);
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic wait_valid(input bit [2:0] q, input bit rd);
        int n = 0;
        while (!inc_valid && n < 40) begin
            tick(1'b0, q, rd);
            n++;
        end
        chk("wait_valid", inc_valid, 1);
    endtask

    task automatic next_grant(input bit [2:0] q);
        tick(1'b0, q, 1'b1);
        wait_valid(q, 1'b1);
    endtask

    bit [2:0] rq;

    initial begin
        rst = 1'b1; req = 3'b010; inc_ready = 1'b1;

        // Reset with a request level already high: no event on release.
        tick(1, 3'b010, 1);
        tick(1, 3'b010, 1);
        chk("rst.inc_valid", inc_valid, 0);
        chk("rst.busy", busy, 0);
        tick(0, 3'b010, 1);
        tick(0, 3'b010, 1);
        chk("rel.pending", pending, 0);
        chk("rel.inc_valid", inc_valid, 0);

        // Single request timing.
        tick(0, 3'b000, 1);
        tick(0, 3'b001, 1);                 // edge k
        chk("single.pending_k", pending, 3'b001);
        chk("single.valid_k", inc_valid, 0);
        tick(0, 3'b000, 1);                 // k+1
        chk("single.valid_k1", inc_valid, 1);
        chk("single.amount", inc_amount, 1);
        chk("single.id", grant_id, 0);
        tick(0, 3'b000, 1);                 // k+2 handshake
        chk("single.valid_k2", inc_valid, 0);
        chk("single.busy_k2", busy, 1);
        tick(0, 3'b000, 1);
        tick(0, 3'b000, 1);
        tick(0, 3'b000, 1);                 // k+5
        chk("single.busy_k5", busy, 1);
        tick(0, 3'b000, 1);                 // k+6
        chk("single.busy_k6", busy, 0);

        // Simultaneous requests served 0,1,2.
        tick(1, 3'b000, 1);
        tick(0, 3'b000, 1);
        tick(0, 3'b111, 1);
        chk("sim.pending0", pending, 3'b111);
        tick(0, 3'b111, 1);
        chk("sim.id0", grant_id, 0);
        chk("sim.amt0", inc_amount, 1);
        chk("sim.pending1", pending, 3'b110);
        next_grant(3'b111);
        chk("sim.id1", grant_id, 1);
        chk("sim.amt1", inc_amount, 2);
        chk("sim.pending2", pending, 3'b100);
        next_grant(3'b111);
        chk("sim.id2", grant_id, 2);
        chk("sim.amt2", inc_amount, 3);
        chk("sim.pending3", pending, 3'b000);
        tick(0, 3'b000, 1);

        // Round-robin: after grant 1, requester 2 beats requester 0.
        tick(1, 3'b000, 1);
        tick(0, 3'b000, 1);
        tick(0, 3'b010, 1);
        tick(0, 3'b010, 1);
        chk("rr.id1", grant_id, 1);
        tick(0, 3'b111, 1);
        chk("rr.pending", pending, 3'b101);
        wait_valid(3'b111, 1);
        chk("rr.id2", grant_id, 2);
        next_grant(3'b111);
        chk("rr.id0", grant_id, 0);
        tick(0, 3'b000, 1);

        // Stall with a lost edge, then a single handshake.
        tick(1, 3'b000, 0);
        tick(0, 3'b000, 0);
        tick(0, 3'b010, 0);
        tick(0, 3'b010, 0);
        chk("stall.id", grant_id, 1);
        tick(0, 3'b011, 0);
        tick(0, 3'b010, 0);
        tick(0, 3'b011, 0);
        chk("stall.valid", inc_valid, 1);
        chk("stall.id_held", grant_id, 1);
        chk("stall.amt_held", inc_amount, 2);
        chk("stall.pending", pending, 3'b001);
        chk("stall.dropped", dropped, 1);
        tick(0, 3'b011, 1);
        chk("stall.after_hs", inc_valid, 0);
        chk("stall.busy", busy, 1);

        // Reset pulsed while an increment is offered.
        wait_valid(3'b011, 0);
        chk("rstiss.id", grant_id, 0);
        tick(1, 3'b011, 0);
        chk("rstiss.valid", inc_valid, 0);
        chk("rstiss.pending", pending, 0);
        chk("rstiss.dropped", dropped, 0);
        tick(0, 3'b011, 1);
        chk("rstiss.no_event", pending, 0);

        // Randomized traffic.
        rq = 3'b000;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) rq = 3'($urandom_range(0, 7));
            tick($urandom_range(0, 249) == 0, rq, $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
